// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment scan driver.
// Glyphs are active low, ordered ABCDEFG with segment A in bit 6.
package seg7_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_glyph_rom.sv
// seg7_glyph_rom: combinational hex nibble to active-low ABCDEFG glyph.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // table lookup of the glyph for the selected nibble
  always_comb begin
    glyph = GLYPH_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed driver for an N-digit common-anode hex
// display. Data is captured into shadow registers on load and one digit is
// lit per slot of CLK_DIV cycles, with a dark guard cycle at every slot start.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens leading-zero digits.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load,
  output logic [6:0]              seg7,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]      presc_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] val_sh_r;
  logic [NUM_DIGITS-1:0]   blank_sh_r;
  logic [NUM_DIGITS-1:0]   dp_sh_r;
  logic [6:0]              seg7_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic                    frame_done_r;

  logic                    tick_s;
  logic [3:0]              nibble_s;
  logic [6:0]              glyph_s;
  logic                    seg_dark_s;
  logic                    dp_dark_s;

  // slot boundary and the nibble of the digit currently being scanned
  always_comb begin
    tick_s   = (presc_r == PRESC_MAX);
    nibble_s = val_sh_r[4*int'(idx_r) +: 4];
  end

  seg7_glyph_rom u_glyph_rom (
    .nibble (nibble_s),
    .glyph  (glyph_s)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_s;
  logic                  zero_above_s;

  // flag digits whose nibble and every higher nibble are zero; digit 0 never
  always_comb begin
    lz_s         = '0;
    zero_above_s = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      zero_above_s = zero_above_s & (val_sh_r[4*d +: 4] == 4'h0);
      lz_s[d]      = zero_above_s;
    end
  end

  // leading-zero digits lose their segments but keep the decimal point
  always_comb begin
    seg_dark_s = blank_sh_r[idx_r] | lz_s[idx_r];
    dp_dark_s  = blank_sh_r[idx_r];
  end
`else
  // only the explicit per-digit blank darkens a digit
  always_comb begin
    seg_dark_s = blank_sh_r[idx_r];
    dp_dark_s  = blank_sh_r[idx_r];
  end
`endif

  // prescaler, digit index and end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r      <= '0;
      idx_r        <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= tick_s && (idx_r == IDX_MAX);
      if (tick_s) begin
        presc_r <= '0;
        if (idx_r == IDX_MAX) begin
          idx_r <= '0;
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end else begin
        presc_r <= presc_r + PRESC_W'(1);
      end
    end
  end

  // shadow capture of the display data on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_sh_r   <= '0;
      blank_sh_r <= '0;
      dp_sh_r    <= '0;
    end else if (load) begin
      val_sh_r   <= value_i;
      blank_sh_r <= blank_i;
      dp_sh_r    <= dp_i;
    end
  end

  // registered pin drivers; the first cycle of each slot is a dark guard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg7_r <= SEG_OFF;
      dp_r   <= 1'b1;
      an_r   <= '1;
    end else if (tick_s) begin
      an_r <= '1;
    end else begin
      an_r   <= ~(NUM_DIGITS'(1) << idx_r);
      seg7_r <= seg_dark_s ? SEG_OFF : glyph_s;
      dp_r   <= dp_dark_s ? 1'b1 : ~dp_sh_r[idx_r];
    end
  end

  assign seg7       = seg7_r;
  assign dp         = dp_r;
  assign an         = an_r;
  assign frame_done = frame_done_r;

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Time-multiplexed driver for an N-digit common-anode hex 7-segment display.
- Latches an N-nibble value on a load strobe and scans one digit per slot.
- Drives shared active-low segment lines plus active-low digit enables.
- Sits between the counter/datapath and the board display pins; replaces per-digit static decoders.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal 1..8)
CLK_DIV, 50000, clk cycles per digit slot (legal >= 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value_i  input  4*NUM_DIGITS  hex nibbles; nibble d = bits [4d+3:4d]; digit 0 is least significant
blank_i  input  NUM_DIGITS  per-digit force-blank, 1 = digit dark
dp_i  input  NUM_DIGITS  per-digit decimal point, 1 = lit
load  input  1  capture value_i/blank_i/dp_i into shadow registers
seg7  output  7  segment lines, order ABCDEFG (bit6 = A), active low
dp  output  1  decimal-point line, active low
an  output  NUM_DIGITS  digit enables, active low, at most one low
frame_done  output  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset, asynchronous active-low:
  - prescaler = 0, digit index = 0, shadow value/blank/dp = 0.
  - seg7 = 7'b1111111, dp = 1, an = all ones, frame_done = 0.
- Shadow capture: on a clk edge with load = 1, the shadow registers take value_i/blank_i/dp_i. The display only ever uses the shadow registers, never the live inputs.
- Prescaler: counts 0..CLK_DIV-1 and wraps. Width is $clog2(CLK_DIV). tick = (prescaler == CLK_DIV-1).
- Digit index: advances on tick. Wraps from NUM_DIGITS-1 to 0. With NUM_DIGITS = 1 the index stays at 0.
- frame_done: registered. High for exactly the one cycle after the edge on which the index wraps to 0. With NUM_DIGITS = 1 it pulses every slot.
- Outputs: all registered and computed every cycle from the current index and shadow state. Latency is 1 clk.
  - load at edge k → new glyph on seg7 at edge k+1 if that digit is active.
  - Index change at edge k → new an/seg7 at edge k+1.
- Anti-ghost guard: for the first cycle of every slot (prescaler == 0), an = all ones and seg7/dp hold their previous values. From the second cycle onward, an[index] = 0 and all other an bits are 1.
- Glyphs, active low, ABCDEFG:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Blanking: if blank for the active digit is 1, seg7 = 1111111 and dp = 1. The an bit is still driven low, so brightness timing stays uniform.
- Decimal point: dp = ~dp_shadow[index] unless the digit is blanked.
- Simultaneous load and tick: both take effect. The next slot shows the newly loaded data.
- Reset asserted mid-scan: immediate return to reset values. The first slot after release is digit 0 after CLK_DIV cycles.

Optional Feature:
Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: a digit is also blanked when its nibble and every higher-order nibble are 0. Digit 0 is never blanked by this rule. dp_i still lights the decimal point of such a digit.
  - Example: value 16'h0040 shows digits 3 and 2 dark.
- Undefined: zeros display as "0". The logic is absent.

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF = 7'b1111111
  - 16-entry glyph constant array
  - typedef nibble_t = logic [3:0]
- Sub-module seg7_glyph_rom: purely combinational nibble_t → 7-bit active-low glyph, indexed from the package table. The scanner instantiates it once, on the muxed nibble.

Test Plan:
- Reset, with NUM_DIGITS=4, CLK_DIV=4: hold rst_n=0 and toggle clk → seg7=1111111, dp=1, an=1111, frame_done=0. Then release rst_n.
- Scan order: load value_i=16'h1234, blank_i=0, dp_i=0. Expect an sequence 1110,1101,1011,0111 with seg7 1001100, 0000110, 0010010, 1001111. Expect an=1111 on each slot's first cycle and frame_done pulsing every 16 cycles.
- Glyph sweep: load each of 16'h0000..16'hFFFF by repeated-nibble patterns (16'h1111, 16'hAAAA, ...) → every digit shows the table glyph, including b=1100000 and F=0111000.
- Blank/dp: load 16'h8888 with blank_i=4'b0100, dp_i=4'b0001 → digit 2 seg7=1111111 but an[2] still low. Digit 0 has dp=0. The other digits have dp=1.
- Load collision: assert load with 16'h00FF on the same edge as tick → the next slot shows the new nibble one cycle after its guard cycle. Live value_i changes without load have no effect.
- Leading-zero blanking (macro on): load 16'h0040 → digits 3 and 2 dark, digit 1 = 1001100, digit 0 = 0000001. Load 16'h0000 → only digit 0 is lit, as 0000001. With the macro off, all four digits show 0000001.
